// File: rtl/param_lock.sv
// Sequence lock with programmable secret, failed-attempt lockout and explicit relock.
// All outputs registered (one cycle after the triggering edge); no backpressure, inputs sampled when valid.
module param_lock #(
    parameter int CODE_W         = 8,
    parameter int SEQ_LEN        = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter logic [SEQ_LEN*CODE_W-1:0] DEFAULT_SEQ = {8'hdd, 8'hcc, 8'hbb, 8'haa},
    localparam int IDX_W = $clog2(SEQ_LEN),
    localparam int PW    = $clog2(SEQ_LEN + 1),
    localparam int FW    = $clog2(MAX_FAILS + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    input  logic              relock,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_idx,
    input  logic [CODE_W-1:0] prog_data,
    output logic [PW-1:0]     progress,
    output logic [FW-1:0]     fail_count,
    output logic              unlocked,
    output logic              locked_out
);

    localparam int LW     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int IDX1_W = IDX_W + 1;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     progress_q, progress_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic              unlocked_q, locked_out_q;
    logic [CODE_W-1:0] secret [SEQ_LEN];
    logic              sec_we;
    logic              idx_ok;
    logic [CODE_W-1:0] expected_sym;

    // Non-power-of-two SEQ_LEN leaves prog_idx codes with no backing symbol.
    assign idx_ok = ({1'b0, prog_idx} < IDX1_W'(SEQ_LEN));

    // progress is always below SEQ_LEN while in ENTRY, so the low bits index the secret.
    assign expected_sym = secret[progress_q[IDX_W-1:0]];

    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        fail_d     = fail_q;
        lock_cnt_d = lock_cnt_q;
        sec_we     = 1'b0;
        case (state_q)
            ENTRY: begin
                if (code_valid) begin
                    if (code == expected_sym) begin
                        if (progress_q == PW'(SEQ_LEN - 1)) begin
                            state_d    = UNLOCKED;
                            progress_d = PW'(SEQ_LEN);
                            fail_d     = '0;
                        end else begin
                            progress_d = progress_q + PW'(1);
                        end
                    end else begin
                        // No overlap matching: the wrong symbol is not retried as symbol 0.
                        progress_d = '0;
                        if (fail_q == FW'(MAX_FAILS - 1)) begin
                            state_d    = LOCKOUT;
                            fail_d     = '0;
                            lock_cnt_d = LW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            fail_d = fail_q + FW'(1);
                        end
                    end
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    state_d    = ENTRY;
                    progress_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - LW'(1);
                end
            end
            UNLOCKED: begin
                sec_we = prog_we && idx_ok;
                if (relock) begin
                    state_d    = ENTRY;
                    progress_d = '0;
                end
            end
            default: begin
                state_d    = ENTRY;
                progress_d = '0;
                fail_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ENTRY;
            progress_q   <= '0;
            fail_q       <= '0;
            lock_cnt_q   <= '0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            progress_q   <= progress_d;
            fail_q       <= fail_d;
            lock_cnt_q   <= lock_cnt_d;
            unlocked_q   <= (state_d == UNLOCKED);
            locked_out_q <= (state_d == LOCKOUT);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                secret[i] <= DEFAULT_SEQ[i*CODE_W +: CODE_W];
            end
        end else if (sec_we) begin
            secret[prog_idx] <= prog_data;
        end
    end

    assign progress   = progress_q;
    assign fail_count = fail_q;
    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;

endmodule

// File: tb/tb_param_lock.sv
// Directed bench for param_lock: reference model feeds a scoreboard queue, popped after each edge.
// A second, 3-symbol instance covers a prog_idx code with no backing symbol.
module tb_param_lock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [7:0] code;
    logic       code_valid, relock, prog_we;
    logic [1:0] prog_idx;
    logic [7:0] prog_data;
    logic [2:0] progress;
    logic [1:0] fail_count;
    logic       unlocked, locked_out;

    logic [7:0] code3;
    logic       code_valid3, relock3, prog_we3;
    logic [1:0] prog_idx3;
    logic [7:0] prog_data3;
    logic [1:0] progress3;
    logic [1:0] fail_count3;
    logic       unlocked3, locked_out3;

    param_lock dut (
        .clk(clk), .reset_n(reset_n), .code(code), .code_valid(code_valid),
        .relock(relock), .prog_we(prog_we), .prog_idx(prog_idx), .prog_data(prog_data),
        .progress(progress), .fail_count(fail_count), .unlocked(unlocked), .locked_out(locked_out)
    );

    param_lock #(.SEQ_LEN(3), .DEFAULT_SEQ(24'hccbbaa)) dut3 (
        .clk(clk), .reset_n(reset_n), .code(code3), .code_valid(code_valid3),
        .relock(relock3), .prog_we(prog_we3), .prog_idx(prog_idx3), .prog_data(prog_data3),
        .progress(progress3), .fail_count(fail_count3), .unlocked(unlocked3), .locked_out(locked_out3)
    );

    typedef struct {
        logic [2:0] prog;
        logic [1:0] fails;
        logic       unl;
        logic       lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0=ENTRY, 1=UNLOCKED, 2=LOCKOUT
    int         m_state, m_prog, m_fail, m_left;
    logic [7:0] m_sec [4];

    task automatic model_step(input logic rst, input logic [7:0] c, input logic v,
                              input logic rl, input logic we, input int idx, input logic [7:0] d);
        if (!rst) begin
            m_state = 0; m_prog = 0; m_fail = 0; m_left = 0;
            m_sec[0] = 8'haa; m_sec[1] = 8'hbb; m_sec[2] = 8'hcc; m_sec[3] = 8'hdd;
        end else if (m_state == 0) begin
            if (v) begin
                if (c == m_sec[m_prog]) begin
                    m_prog++;
                    if (m_prog == 4) begin m_state = 1; m_fail = 0; end
                end else begin
                    m_prog = 0;
                    m_fail++;
                    if (m_fail == 3) begin m_state = 2; m_fail = 0; m_left = 16; end
                end
            end
        end else if (m_state == 2) begin
            m_left--;
            if (m_left == 0) begin m_state = 0; m_prog = 0; end
        end else begin
            if (we && idx < 4) m_sec[idx] = d;
            if (rl) begin m_state = 0; m_prog = 0; end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [7:0] c, input logic v, input logic rl,
                        input logic we, input logic [1:0] idx, input logic [7:0] d);
        exp_t e;
        reset_n = rst; code = c; code_valid = v; relock = rl;
        prog_we = we; prog_idx = idx; prog_data = d;
        model_step(rst, c, v, rl, we, int'(idx), d);
        e.prog = 3'(m_prog); e.fails = 2'(m_fail); e.unl = (m_state == 1); e.lo = (m_state == 2);
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk("progress",   {29'b0, progress},   {29'b0, e.prog});
        chk("fail_count", {30'b0, fail_count}, {30'b0, e.fails});
        chk("unlocked",   {31'b0, unlocked},   {31'b0, e.unl});
        chk("locked_out", {31'b0, locked_out}, {31'b0, e.lo});
        reset_n = 1'b1; code_valid = 1'b0; relock = 1'b0; prog_we = 1'b0;
    endtask

    task automatic sym(input logic [7:0] c);
        step(1'b1, c, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic idle();
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic step3(input logic [7:0] c, input logic v, input logic rl,
                         input logic we, input logic [1:0] idx, input logic [7:0] d);
        code3 = c; code_valid3 = v; relock3 = rl; prog_we3 = we; prog_idx3 = idx; prog_data3 = d;
        @(posedge clk); #1;
        code_valid3 = 1'b0; relock3 = 1'b0; prog_we3 = 1'b0;
    endtask

    int lo_cycles;
    int n;

    initial begin
        reset_n = 1'b0; code = '0; code_valid = 1'b0; relock = 1'b0;
        prog_we = 1'b0; prog_idx = '0; prog_data = '0;
        code3 = '0; code_valid3 = 1'b0; relock3 = 1'b0;
        prog_we3 = 1'b0; prog_idx3 = '0; prog_data3 = '0;

        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("reset_unlocked", {31'b0, unlocked}, 32'd0);

        // Default secret, back to back
        sym(8'haa); sym(8'hbb); sym(8'hcc); sym(8'hdd);
        chk("unlock_default", {31'b0, unlocked}, 32'd1);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);

        // Gaps of 3 idle cycles hold progress
        sym(8'haa); idle(); idle(); idle();
        sym(8'hbb); idle(); idle(); idle();
        chk("gap_progress", {29'b0, progress}, 32'd2);
        sym(8'hcc); sym(8'hdd);
        chk("unlock_gaps", {31'b0, unlocked}, 32'd1);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);

        // Mismatch after one good symbol
        sym(8'haa); sym(8'hee);
        chk("mismatch_fail", {30'b0, fail_count}, 32'd1);
        sym(8'haa); sym(8'hbb); sym(8'hcc); sym(8'hdd);
        chk("unlock_after_fail", {31'b0, unlocked}, 32'd1);
        chk("fail_cleared", {30'b0, fail_count}, 32'd0);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);

        // Three wrong symbols -> lockout; correct symbols during lockout ignored
        sym(8'h11); sym(8'h22); sym(8'h33);
        lo_cycles = locked_out ? 1 : 0;
        n = 0;
        while (locked_out && n < 40) begin
            sym(8'haa + 8'(8'h11 * (n % 4)));
            if (locked_out) lo_cycles++;
            n++;
        end
        chk("lockout_len", lo_cycles, 32'd16);
        chk("post_lock_prog", {29'b0, progress}, 32'd0);
        sym(8'haa); sym(8'hbb); sym(8'hcc); sym(8'hdd);
        chk("unlock_post_lock", {31'b0, unlocked}, 32'd1);

        // Write symbol 0 with relock in the same cycle
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 8'h5a);
        chk("relock_with_write", {31'b0, unlocked}, 32'd0);
        sym(8'haa);
        chk("old_sym_rejected", {30'b0, fail_count}, 32'd1);
        sym(8'h5a); sym(8'hbb); sym(8'hcc); sym(8'hdd);
        chk("unlock_new_secret", {31'b0, unlocked}, 32'd1);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);

        // Reset mid-entry restores default secret; writes in ENTRY ignored
        sym(8'h5a); sym(8'hbb); sym(8'hcc);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("reset_mid_entry", {29'b0, progress}, 32'd0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h77);
        sym(8'haa); sym(8'hbb); sym(8'hcc); sym(8'hdd);
        chk("unlock_default_restored", {31'b0, unlocked}, 32'd1);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);

        // 3-symbol instance: prog_idx 3 has no symbol and must not wrap onto symbol 0
        step3(8'haa, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        step3(8'hbb, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        step3(8'hcc, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("dut3_unlock", {31'b0, unlocked3}, 32'd1);
        chk("dut3_progress", {30'b0, progress3}, 32'd3);
        step3(8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 8'h5a);
        step3(8'h00, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        chk("dut3_relocked", {31'b0, unlocked3}, 32'd0);
        step3(8'haa, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        step3(8'hbb, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        step3(8'hcc, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("dut3_idx_oob_ignored", {31'b0, unlocked3}, 32'd1);
        chk("dut3_no_fail", {30'b0, fail_count3}, 32'd0);
        chk("dut3_not_locked", {31'b0, locked_out3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
